// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester frame-locked arbiter feeding one UART transmitter byte stream
// A requester owns the transmitter from its first byte until its last byte drains, or until it idles too long.
module uart_tx_arb #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    rq_valid,
  input  logic [7:0]    rq_data0,
  input  logic [7:0]    rq_data1,
  input  logic [1:0]    rq_last,
  output logic [1:0]    rq_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          err_timeout,
  output logic [CW-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          forced_q, forced_d;
  logic [1:0]    grant_q, grant_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          err_q, err_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;

  logic          win;
  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;
  logic          own_rdy;

  assign own_valid = rq_valid[owner_q];
  assign own_last  = rq_last[owner_q];
  assign own_data  = owner_q ? rq_data1 : rq_data0;
  assign own_rdy   = !tx_valid_q || tx_ready;
  // With both requesting, the one not granted last time wins.
  assign win       = (rq_valid == 2'b11) ? ~last_q : rq_valid[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      forced_q    <= 1'b0;
      grant_q     <= 2'b00;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      forced_q    <= forced_d;
      grant_q     <= grant_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    forced_d    = forced_q;
    grant_d     = grant_q;
    tx_valid_d  = tx_valid_q && !tx_ready;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    to_cnt_d    = to_cnt_q;
    rq_ready    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (|rq_valid) begin
          owner_d  = win;
          grant_d  = win ? 2'b10 : 2'b01;
          to_cnt_d = '0;
          forced_d = 1'b0;
          state_d  = S_LOCK;
        end
      end

      S_LOCK: begin
        rq_ready[owner_q] = own_rdy;
        if (own_valid && own_rdy) begin
          tx_data_d  = own_data;
          tx_valid_d = 1'b1;
          to_cnt_d   = '0;
          if (own_last) state_d = S_DRAIN;
        end else if (!own_valid) begin
          // Only an idle owner ages the lock; a downstream stall never does.
          if (to_cnt_q == CW'(TIMEOUT - 1)) begin
            err_d    = 1'b1;
            forced_d = 1'b1;
            to_cnt_d = '0;
            state_d  = S_DRAIN;
          end else begin
            to_cnt_d = to_cnt_q + CW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (!tx_valid_q) begin
          state_d  = S_IDLE;
          grant_d  = 2'b00;
          last_d   = owner_q;
          forced_d = 1'b0;
          if (!forced_q) frame_cnt_d = frame_cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed and randomized checks of uart_tx_arb against a frame-order model
module tb_uart_tx_arb;
  localparam int TIMEOUT = 16;
  localparam int CW      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rq_valid;
  logic [7:0]    rq_data0, rq_data1;
  logic [1:0]    rq_last;
  logic [1:0]    rq_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [1:0]    grant;
  logic          busy;
  logic          err_timeout;
  logic [CW-1:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int fc_model = 0;
  int next_rr = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_arb #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .rq_valid(rq_valid), .rq_data0(rq_data0), .rq_data1(rq_data1), .rq_last(rq_last),
    .rq_ready(rq_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rq_valid = 2'b00;
    rq_last  = 2'b00;
    rq_data0 = 8'h00;
    rq_data1 = 8'h00;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    fc_model = 0;
    next_rr = 0;
  endtask

  // Both requesters keep a frame pending, so the model serves frames strictly alternately.
  task automatic run_random(input int nf, input int stall_at, input int stall_len);
    logic [8:0] t0[$];
    logic [8:0] t1[$];
    logic [8:0] popped;
    int len, gap0, gap1, cyc, extra, err_seen, budget;
    bit hs0, hs1;
    for (int f = 0; f < nf; f++) begin
      t0.delete();
      t1.delete();
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) t0.push_back({(b == len - 1), 8'($urandom)});
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) t1.push_back({(b == len - 1), 8'($urandom)});
      foreach (t0[i]) q0.push_back(t0[i]);
      foreach (t1[i]) q1.push_back(t1[i]);
      if (next_rr == 0) begin
        foreach (t0[i]) exp_q.push_back(t0[i][7:0]);
        foreach (t1[i]) exp_q.push_back(t1[i][7:0]);
      end else begin
        foreach (t1[i]) exp_q.push_back(t1[i][7:0]);
        foreach (t0[i]) exp_q.push_back(t0[i][7:0]);
      end
    end
    fc_model += 2 * nf;
    gap0 = 0; gap1 = 0; cyc = 0; extra = 0; err_seen = 0;
    budget = 20000 + stall_len;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      rq_valid[0] = (q0.size() != 0) && (gap0 == 0);
      rq_data0    = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      rq_last[0]  = (q0.size() != 0) ? q0[0][8] : 1'b0;
      rq_valid[1] = (q1.size() != 0) && (gap1 == 0);
      rq_data1    = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      rq_last[1]  = (q1.size() != 0) ? q1[0][8] : 1'b0;
      if (cyc >= stall_at && cyc < stall_at + stall_len) tx_ready = 1'b0;
      else tx_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs0 = rq_valid[0] && rq_ready[0];
      hs1 = rq_valid[1] && rq_ready[1];
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) extra++;
        else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (err_timeout) err_seen++;
      step();
      if (hs0) begin
        popped = q0.pop_front();
        gap0 = popped[8] ? 0 : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
      end else if (gap0 > 0) gap0--;
      if (hs1) begin
        popped = q1.pop_front();
        gap1 = popped[8] ? 0 : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
      end else if (gap1 > 0) gap1--;
      cyc++;
    end
    idle_inputs();
    tx_ready = 1'b1;
    repeat (4) step();
    chk("rand_left", 32'(exp_q.size()), 0);
    chk("rand_extra", 32'(extra), 0);
    chk("rand_err", 32'(err_seen), 0);
    chk("rand_busy", 32'(busy), 0);
    chk("rand_fcnt", 32'(frame_cnt), 32'(fc_model % 16));
    q0.delete();
    q1.delete();
    exp_q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_rdy", 32'(rq_ready), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);

    // Single three-byte frame from requester 0
    tx_ready = 1'b1;
    rq_valid = 2'b01; rq_data0 = 8'h11; rq_last = 2'b00;
    chk("sf_idle_rdy", 32'(rq_ready), 0);
    step();
    chk("sf_grant", 32'(grant), 32'h1);
    chk("sf_txv0", 32'(tx_valid), 0);
    chk("sf_rdy", 32'(rq_ready), 32'h1);
    step();
    rq_data0 = 8'h22;
    chk("sf_b0", 32'({tx_valid, tx_data}), 32'h111);
    step();
    rq_data0 = 8'h33; rq_last = 2'b01;
    chk("sf_b1", 32'({tx_valid, tx_data}), 32'h122);
    step();
    idle_inputs();
    chk("sf_b2", 32'({tx_valid, tx_data}), 32'h133);
    chk("sf_drain_busy", 32'(busy), 1);
    step();
    chk("sf_txv_off", 32'(tx_valid), 0);
    chk("sf_fcnt0", 32'(frame_cnt), 0);
    step();
    chk("sf_grant_end", 32'(grant), 0);
    chk("sf_fcnt1", 32'(frame_cnt), 1);

    // Contention right after reset: requester 0 first, then requester 1
    do_reset();
    tx_ready = 1'b1;
    rq_valid = 2'b11; rq_data0 = 8'h5A; rq_data1 = 8'hA5; rq_last = 2'b11;
    step();
    chk("ct_grant0", 32'(grant), 32'h1);
    chk("ct_rdy0", 32'(rq_ready), 32'h1);
    step();
    rq_valid = 2'b10;
    chk("ct_b0", 32'(tx_data), 32'h5A);
    step();
    step();
    chk("ct_idle", 32'(grant), 0);
    step();
    chk("ct_grant1", 32'(grant), 32'h2);
    step();
    idle_inputs();
    chk("ct_b1", 32'(tx_data), 32'hA5);
    repeat (2) step();
    chk("ct_fcnt", 32'(frame_cnt), 2);

    // Owner goes idle mid-frame: forced release after TIMEOUT idle cycles
    do_reset();
    tx_ready = 1'b1;
    rq_valid = 2'b11; rq_data0 = 8'hA1; rq_data1 = 8'hB1; rq_last = 2'b10;
    step();
    chk("to_grant0", 32'(grant), 32'h1);
    step();
    rq_valid = 2'b10;
    chk("to_b0", 32'({tx_valid, tx_data}), 32'h1A1);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("to_pulse", 32'(err_timeout), 32'(i == 16));
    end
    step();
    chk("to_pulse_end", 32'(err_timeout), 0);
    chk("to_grant_idle", 32'(grant), 0);
    chk("to_fcnt", 32'(frame_cnt), 0);
    step();
    chk("to_grant1", 32'(grant), 32'h2);
    step();
    idle_inputs();
    chk("to_b1", 32'(tx_data), 32'hB1);
    repeat (2) step();
    chk("to_fcnt_after", 32'(frame_cnt), 1);

    // Randomized alternation, then a second run chained without reset
    do_reset();
    run_random(8, 1000000, 0);
    run_random(6, 1000000, 0);

    // Long downstream stall mid-frame must not time out
    do_reset();
    run_random(4, 10, 5000);

    // Reset while a byte is pending downstream
    tx_ready = 1'b0;
    rq_valid = 2'b01; rq_data0 = 8'h77; rq_last = 2'b00;
    step();
    step();
    chk("rm_txv", 32'(tx_valid), 1);
    rst = 1'b1;
    step();
    chk("rm_txv_off", 32'(tx_valid), 0);
    chk("rm_grant", 32'(grant), 0);
    chk("rm_fcnt", 32'(frame_cnt), 0);
    chk("rm_err", 32'(err_timeout), 0);
    chk("rm_rdy", 32'(rq_ready), 0);
    rst = 1'b0;
    idle_inputs();
    fc_model = 0;
    tx_ready = 1'b1;
    repeat (3) step();
    chk("rm_quiet", 32'({busy, tx_valid}), 0);

    // Frame counter wraps after 16 single-byte frames
    for (int k = 0; k < 16; k++) begin
      rq_valid = 2'b01; rq_data0 = 8'(k + 8'h40); rq_last = 2'b01;
      step();
      step();
      idle_inputs();
      chk("wrap_byte", 32'(tx_data), 32'(k + 8'h40));
      step();
      step();
      fc_model++;
      chk("wrap_cnt", 32'(frame_cnt), 32'(fc_model % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
